// File: rtl/board_update_scheduler.sv
// Arbitrates the Tetris board cell RAM: scan-position lookups during active video,
// buffered game-logic writes and board clears committed only during vertical blanking.
module board_update_scheduler #(
    parameter int BLOCK_SIZE   = 32,
    parameter int VIDEO_WIDTH  = 640,
    parameter int VIDEO_HEIGHT = 480,
    parameter int FIFO_DEPTH   = 16,
    parameter int COLOR_W      = 3
) (
    input  logic               clk,
    input  logic               RESET_n,
    input  logic [9:0]         col,
    input  logic [8:0]         row,
    input  logic               video_active,
    input  logic               vblank,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [4:0]         wr_x,
    input  logic [3:0]         wr_y,
    input  logic [COLOR_W-1:0] wr_color,
    input  logic               clear_req,
    output logic               busy,
    output logic               frame_done,
    output logic               drop_err,
    output logic [8:0]         ram_addr,
    output logic               ram_we,
    output logic [COLOR_W-1:0] ram_wdata,
    input  logic [COLOR_W-1:0] ram_rdata,
    output logic [COLOR_W-1:0] cell_color
);

    localparam int LOG2_BS     = $clog2(BLOCK_SIZE);
    localparam int GRID_WIDTH  = VIDEO_WIDTH / BLOCK_SIZE;
    localparam int GRID_HEIGHT = VIDEO_HEIGHT / BLOCK_SIZE;
    localparam int CELLS       = GRID_WIDTH * GRID_HEIGHT;
    localparam int ADDR_W      = 9;
    localparam int PTR_W       = $clog2(FIFO_DEPTH);
    localparam int CNT_W       = PTR_W + 1;
    localparam int ENTRY_W     = 5 + 4 + COLOR_W;
    localparam int VA_DELAY    = 2;

    typedef enum logic [1:0] {DISPLAY, CLEAR, DRAIN} state_t;

    state_t              state_reg, state_next;
    logic                vblank_q_reg;
    logic                clear_pending_reg;
    logic                clear_again_reg;
    logic [ADDR_W-1:0]   clr_addr_reg, clr_addr_next;
    logic [ENTRY_W-1:0]  fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]    count_reg, count_next;
    logic                ram_we_reg, ram_we_next;
    logic [ADDR_W-1:0]   ram_addr_reg, ram_addr_next;
    logic [COLOR_W-1:0]  ram_wdata_reg, ram_wdata_next;
    logic                frame_done_reg, frame_done_next;
    logic                drop_err_reg;
    logic [COLOR_W-1:0]  cell_color_reg, cell_color_next;
    logic [VA_DELAY-1:0] va_pipe_reg, va_pipe_next;

    logic                rise, push, pop, drop_set, clear_done;
    logic [ENTRY_W-1:0]  head;
    logic [4:0]          head_x;
    logic [3:0]          head_y;
    logic [COLOR_W-1:0]  head_color;
    logic                head_in_range;
    logic [ADDR_W-1:0]   head_addr, scan_addr;
    logic [9:0]          col_cell;
    logic [8:0]          row_cell;

    assign rise     = vblank & ~vblank_q_reg;
    assign wr_ready = (count_reg != CNT_W'(FIFO_DEPTH));
    assign push     = wr_valid & wr_ready;

    assign head          = fifo_mem[rd_ptr_reg];
    assign head_x        = head[ENTRY_W-1 -: 5];
    assign head_y        = head[COLOR_W +: 4];
    assign head_color    = head[COLOR_W-1:0];
    assign head_in_range = (int'(head_x) < GRID_WIDTH) && (int'(head_y) < GRID_HEIGHT);
    assign head_addr     = ADDR_W'(int'(head_y) * GRID_WIDTH + int'(head_x));

    assign col_cell  = col >> LOG2_BS;
    assign row_cell  = row >> LOG2_BS;
    assign scan_addr = ADDR_W'(int'(row_cell) * GRID_WIDTH + int'(col_cell));

    // video_active travels alongside the address/read-data pipeline
    genvar gi;
    generate
        for (gi = 0; gi < VA_DELAY; gi++) begin : g_va
            if (gi == 0) begin : g_first
                assign va_pipe_next[gi] = video_active;
            end else begin : g_rest
                assign va_pipe_next[gi] = va_pipe_reg[gi-1];
            end
        end
    endgenerate

    always_comb begin
        state_next      = state_reg;
        clr_addr_next   = clr_addr_reg;
        ram_we_next     = 1'b0;
        ram_addr_next   = ram_addr_reg;
        ram_wdata_next  = '0;
        frame_done_next = 1'b0;
        pop             = 1'b0;
        drop_set        = 1'b0;
        clear_done      = 1'b0;
        case (state_reg)
            DISPLAY: begin
                ram_addr_next = scan_addr;
                clr_addr_next = '0;
                if (rise)
                    state_next = clear_pending_reg ? CLEAR : DRAIN;
            end
            CLEAR: begin
                if (!vblank) begin
                    state_next    = DISPLAY;
                    clr_addr_next = '0;
                end else begin
                    ram_we_next   = 1'b1;
                    ram_addr_next = clr_addr_reg;
                    if (clr_addr_reg == ADDR_W'(CELLS - 1)) begin
                        clear_done    = 1'b1;
                        clr_addr_next = '0;
                        state_next    = DRAIN;
                    end else begin
                        clr_addr_next = clr_addr_reg + ADDR_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (!vblank) begin
                    state_next = DISPLAY;
                end else if (count_reg == '0) begin
                    frame_done_next = 1'b1;
                    state_next      = DISPLAY;
                end else begin
                    pop = 1'b1;
                    if (head_in_range) begin
                        ram_we_next    = 1'b1;
                        ram_addr_next  = head_addr;
                        ram_wdata_next = head_color;
                    end else begin
                        drop_set = 1'b1;
                    end
                end
            end
            default: state_next = DISPLAY;
        endcase
    end

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    // Blank the colour on the cycle the FSM leaves DISPLAY as well
    assign cell_color_next = (state_reg == DISPLAY && state_next == DISPLAY
                              && va_pipe_reg[VA_DELAY-1]) ? ram_rdata : '0;

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr_reg] <= {wr_x, wr_y, wr_color};
    end

    always_ff @(posedge clk) begin
        if (!RESET_n) begin
            state_reg         <= DISPLAY;
            vblank_q_reg      <= 1'b0;
            clear_pending_reg <= 1'b1;
            clear_again_reg   <= 1'b0;
            clr_addr_reg      <= '0;
            wr_ptr_reg        <= '0;
            rd_ptr_reg        <= '0;
            count_reg         <= '0;
            ram_we_reg        <= 1'b0;
            ram_addr_reg      <= '0;
            ram_wdata_reg     <= '0;
            frame_done_reg    <= 1'b0;
            drop_err_reg      <= 1'b0;
            cell_color_reg    <= '0;
            va_pipe_reg       <= '0;
        end else begin
            state_reg      <= state_next;
            vblank_q_reg   <= vblank;
            clr_addr_reg   <= clr_addr_next;
            count_reg      <= count_next;
            ram_we_reg     <= ram_we_next;
            ram_addr_reg   <= ram_addr_next;
            ram_wdata_reg  <= ram_wdata_next;
            frame_done_reg <= frame_done_next;
            cell_color_reg <= cell_color_next;
            va_pipe_reg    <= va_pipe_next;
            if (push)
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            if (drop_set)
                drop_err_reg <= 1'b1;
            // A request seen while clearing re-arms the clear for the next blanking
            clear_pending_reg <= clear_req | (clear_done ? clear_again_reg : clear_pending_reg);
            if (state_reg != CLEAR)
                clear_again_reg <= 1'b0;
            else if (clear_req)
                clear_again_reg <= 1'b1;
        end
    end

    assign busy       = clear_pending_reg | (count_reg != '0) | (state_reg != DISPLAY);
    assign frame_done = frame_done_reg;
    assign drop_err   = drop_err_reg;
    assign ram_addr   = ram_addr_reg;
    assign ram_we     = ram_we_reg;
    assign ram_wdata  = ram_wdata_reg;
    assign cell_color = cell_color_reg;

endmodule

// File: tb/tb_board_update_scheduler.sv
// Bench for board_update_scheduler: cell RAM model, directed sequences, a command table
// and randomized frames checked against a board/queue reference model.
module tb_board_update_scheduler;

    localparam int COLOR_W = 3;
    localparam int GW      = 20;
    localparam int GH      = 15;

    logic               clk = 1'b0;
    logic               RESET_n = 1'b0;
    logic [9:0]         col = '0;
    logic [8:0]         row = '0;
    logic               video_active = 1'b0;
    logic               vblank = 1'b0;
    logic               wr_valid = 1'b0;
    logic               wr_ready;
    logic [4:0]         wr_x = '0;
    logic [3:0]         wr_y = '0;
    logic [COLOR_W-1:0] wr_color = '0;
    logic               clear_req = 1'b0;
    logic               busy, frame_done, drop_err;
    logic [8:0]         ram_addr;
    logic               ram_we;
    logic [COLOR_W-1:0] ram_wdata;
    logic [COLOR_W-1:0] ram_rdata = '0;
    logic [COLOR_W-1:0] cell_color;

    board_update_scheduler dut (
        .clk(clk), .RESET_n(RESET_n), .col(col), .row(row),
        .video_active(video_active), .vblank(vblank),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_x(wr_x), .wr_y(wr_y),
        .wr_color(wr_color), .clear_req(clear_req), .busy(busy),
        .frame_done(frame_done), .drop_err(drop_err), .ram_addr(ram_addr),
        .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .cell_color(cell_color)
    );

    always #5 clk = ~clk;

    // Synchronous cell RAM seen by the DUT
    logic [COLOR_W-1:0] mem [512];
    always @(posedge clk) begin
        if (ram_we)
            mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; int addr; int data; } wr_t;
    wr_t wq[$];
    int  fq[$];
    always @(negedge clk) begin
        if (ram_we === 1'b1)
            wq.push_back('{cyc, int'(ram_addr), int'(ram_wdata)});
        if (frame_done === 1'b1)
            fq.push_back(cyc);
    end

    int vectors = 0;
    int fails   = 0;
    int exp_a[$];
    int exp_d[$];
    int board[GW*GH];
    logic drop_model = 1'b0;

    task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int x, input int y, input int c);
        wr_x = 5'(x); wr_y = 4'(y); wr_color = COLOR_W'(c);
        wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
        $display("push x=%0d y=%0d color=%0d", x, y, c);
    endtask

    task automatic run_blank(input int n);
        vblank = 1'b1;
        repeat (n) tick();
        vblank = 1'b0;
        tick();
        tick();
    endtask

    task automatic clear_logs();
        wq.delete(); fq.delete(); exp_a.delete(); exp_d.delete();
    endtask

    task automatic expect_clear();
        for (int a = 0; a < GW*GH; a++) begin
            exp_a.push_back(a); exp_d.push_back(0); board[a] = 0;
        end
    endtask

    task automatic expect_cmd(input int x, input int y, input int c);
        if (x < GW && y < GH) begin
            exp_a.push_back(y*GW + x); exp_d.push_back(c); board[y*GW + x] = c;
        end else begin
            drop_model = 1'b1;
        end
    endtask

    task automatic check_writes(input string name, input bit tight);
        int bad = -1;
        check({name, "_nwrites"}, wq.size(), exp_a.size());
        for (int i = 0; i < wq.size() && i < exp_a.size(); i++)
            if (bad < 0 && (wq[i].addr != exp_a[i] || wq[i].data != exp_d[i]))
                bad = i;
        check({name, "_first_bad_idx"}, bad, -1);
        check({name, "_frame_done_cnt"}, fq.size(), 1);
        if (tight && wq.size() > 0) begin
            check({name, "_burst_span"}, wq[wq.size()-1].cyc - wq[0].cyc, wq.size() - 1);
            if (fq.size() > 0)
                check({name, "_done_timing"}, fq[0], wq[wq.size()-1].cyc + 1);
        end
        $display("frame %s: %0d writes, %0d frame_done", name, wq.size(), fq.size());
    endtask

    task automatic scan(input string name, input int c, input int r, input logic va, input int exp);
        col = 10'(c); row = 9'(r); video_active = va;
        tick(); tick(); tick();
        check(name, cell_color, exp);
        video_active = 1'b0;
        $display("scan col=%0d row=%0d va=%0b color=%0d", c, r, va, cell_color);
    endtask

    typedef struct { int x; int y; int c; int addr; } cmd_vec_t;
    typedef struct { int col; int row; logic va; int color; } scan_vec_t;
    cmd_vec_t  cmd_tab [8];
    scan_vec_t scan_tab[7];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c0, nb, guard;
        cmd_tab[0] = '{3, 2, 5, 43};
        cmd_tab[1] = '{19, 14, 7, 299};
        cmd_tab[2] = '{0, 0, 1, 0};
        cmd_tab[3] = '{20, 0, 2, -1};
        cmd_tab[4] = '{0, 15, 3, -1};
        cmd_tab[5] = '{19, 0, 2, 19};
        cmd_tab[6] = '{31, 15, 4, -1};
        cmd_tab[7] = '{0, 14, 6, 280};
        scan_tab[0] = '{100, 70, 1'b1, 5};
        scan_tab[1] = '{639, 479, 1'b1, 7};
        scan_tab[2] = '{0, 0, 1'b1, 1};
        scan_tab[3] = '{610, 10, 1'b1, 2};
        scan_tab[4] = '{5, 470, 1'b1, 6};
        scan_tab[5] = '{100, 70, 1'b0, 0};
        scan_tab[6] = '{320, 240, 1'b1, 0};
        for (int a = 0; a < GW*GH; a++) board[a] = 0;

        // Reset values
        RESET_n = 1'b0;
        tick(); tick();
        check("rst_ram_we", ram_we, 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_ram_wdata", ram_wdata, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_drop_err", drop_err, 0);
        check("rst_cell_color", cell_color, 0);
        RESET_n = 1'b1;
        tick();
        check("rst_wr_ready", wr_ready, 1);
        check("rst_busy", busy, 1);

        // First blanking clears the whole board
        clear_logs();
        expect_clear();
        c0 = cyc;
        run_blank(310);
        check_writes("first_clear", 1'b1);
        if (wq.size() > 0) check("first_clear_latency", wq[0].cyc - c0, 2);
        check("first_clear_busy", busy, 0);

        // Single buffered write, then read latency on that cell
        clear_logs();
        push(3, 2, 5);
        expect_cmd(3, 2, 5);
        repeat (5) tick();
        check("buf_no_early_write", wq.size(), 0);
        check("buf_busy_queued", busy, 1);
        run_blank(10);
        check_writes("buf_write", 1'b1);
        col = 0; row = 0; video_active = 1'b1;
        repeat (3) tick();
        col = 100; row = 70;
        tick();
        check("lat_ram_addr", ram_addr, 43);
        tick();
        check("lat_cycle2_old", cell_color, 0);
        tick();
        check("lat_cycle3_new", cell_color, 5);
        video_active = 1'b0;

        // FIFO full: 16 accepted, the 17th held off
        clear_logs();
        for (int i = 0; i < 16; i++) begin
            if (i == 15) check("full_ready_at15", wr_ready, 1);
            push(i, 5, i % 8);
            expect_cmd(i, 5, i % 8);
        end
        check("full_ready_low", wr_ready, 0);
        wr_x = 5'd10; wr_y = 4'd10; wr_color = 3'd7; wr_valid = 1'b1;
        repeat (3) tick();
        wr_valid = 1'b0;
        check("full_ready_still_low", wr_ready, 0);
        run_blank(30);
        check_writes("full_fifo", 1'b1);
        check("full_ready_after", wr_ready, 1);

        // Command table including out-of-range entries
        clear_logs();
        foreach (cmd_tab[i]) begin
            push(cmd_tab[i].x, cmd_tab[i].y, cmd_tab[i].c);
            if (cmd_tab[i].addr >= 0) begin
                exp_a.push_back(cmd_tab[i].addr);
                exp_d.push_back(cmd_tab[i].c);
                board[cmd_tab[i].addr] = cmd_tab[i].c;
            end else begin
                drop_model = 1'b1;
            end
        end
        run_blank(30);
        check_writes("table", 1'b0);
        check("table_drop_err", drop_err, 1);
        foreach (scan_tab[i])
            scan($sformatf("table_scan%0d", i), scan_tab[i].col, scan_tab[i].row,
                 scan_tab[i].va, scan_tab[i].color);

        // Push on the same cycle the only queued entry pops
        clear_logs();
        push(1, 1, 3);
        c0 = cyc;
        vblank = 1'b1;
        tick();
        wr_x = 5'd2; wr_y = 4'd1; wr_color = 3'd4; wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
        repeat (4) tick();
        vblank = 1'b0;
        tick();
        board[21] = 3; board[22] = 4;
        check("pp_nwrites", wq.size(), 2);
        if (wq.size() == 2) begin
            check("pp_first_addr", wq[0].addr, 21);
            check("pp_first_cyc", wq[0].cyc - c0, 2);
            check("pp_second_addr", wq[1].addr, 22);
            check("pp_second_cyc", wq[1].cyc - c0, 3);
        end
        check("pp_done_cnt", fq.size(), 1);
        if (fq.size() == 1) check("pp_done_cyc", fq[0] - c0, 4);

        // Clear interrupted by the end of blanking, then restarted from zero
        clear_logs();
        clear_req = 1'b1; tick(); clear_req = 1'b0;
        check("intr_busy_pending", busy, 1);
        vblank = 1'b1;
        guard = 0;
        while (wq.size() < 100 && guard < 400) begin
            tick();
            guard++;
        end
        check("intr_reached_100", wq.size() >= 100, 1);
        vblank = 1'b0;
        repeat (3) tick();
        nb = wq.size();
        tick(); tick();
        check("intr_stopped", wq.size(), nb);
        check("intr_we_low", ram_we, 0);
        check("intr_busy", busy, 1);
        check("intr_no_done", fq.size(), 0);
        if (wq.size() > 0) check("intr_start_addr", wq[0].addr, 0);
        clear_logs();
        expect_clear();
        run_blank(340);
        check_writes("reclear", 1'b1);
        check("reclear_busy", busy, 0);

        // Randomized frames against the board/queue model
        for (int f = 0; f < 6; f++) begin
            int n, kclr;
            bit clr, dropped;
            clear_logs();
            clr = ($urandom_range(0, 2) == 0);
            n = $urandom_range(0, 10);
            kclr = $urandom_range(0, n);
            dropped = 1'b0;
            if (clr) expect_clear();
            for (int i = 0; i <= n; i++) begin
                if (clr && i == kclr) begin
                    clear_req = 1'b1; tick(); clear_req = 1'b0;
                end
                if (i < n) begin
                    int x, y, c;
                    x = $urandom_range(0, 21);
                    y = $urandom_range(0, 15);
                    c = $urandom_range(0, 7);
                    check("rnd_ready", wr_ready, 1);
                    push(x, y, c);
                    expect_cmd(x, y, c);
                    if (x >= GW || y >= GH) dropped = 1'b1;
                    repeat ($urandom_range(0, 2)) tick();
                end
            end
            run_blank(340);
            check_writes($sformatf("rnd%0d", f), !dropped);
            check("rnd_busy_idle", busy, 0);
            check("rnd_drop_err", drop_err, drop_model);
            nb = 0;
            for (int a = 0; a < GW*GH; a++)
                if (int'(mem[a]) != board[a]) nb++;
            check("rnd_board_cells_wrong", nb, 0);
            for (int s = 0; s < 4; s++) begin
                int c, r;
                logic va;
                c = $urandom_range(0, 639);
                r = $urandom_range(0, 479);
                va = ($urandom_range(0, 4) != 0);
                scan("rnd_scan", c, r, va, va ? board[(r/32)*GW + c/32] : 0);
            end
        end

        // Reset in the middle of a clear
        clear_req = 1'b1; tick(); clear_req = 1'b0;
        vblank = 1'b1;
        repeat (20) tick();
        RESET_n = 1'b0;
        tick();
        check("mid_rst_we", ram_we, 0);
        check("mid_rst_addr", ram_addr, 0);
        check("mid_rst_drop_err", drop_err, 0);
        check("mid_rst_frame_done", frame_done, 0);
        check("mid_rst_busy", busy, 1);
        check("mid_rst_ready", wr_ready, 1);
        RESET_n = 1'b1;
        vblank = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

// File: doc/board_update_scheduler.md
# board_update_scheduler

Sequences all access to the Tetris board cell RAM, which holds one colour index per grid cell: GRID_WIDTH × GRID_HEIGHT = 20 × 15 cells at defaults. The block sits between game logic and the VGA renderer. During active video it owns the RAM read port and looks up the cell under the current scan position. Game-logic cell writes and board-clear requests are buffered and committed only during vertical blanking, so the display never tears mid-frame.

## Interface
- BLOCK_SIZE, 32, pixel edge of one cell; must be a power of two.
- VIDEO_WIDTH, 640, active pixels per line; GRID_WIDTH = VIDEO_WIDTH/BLOCK_SIZE.
- VIDEO_HEIGHT, 480, active lines; GRID_HEIGHT = VIDEO_HEIGHT/BLOCK_SIZE.
- FIFO_DEPTH, 16, write-command buffer entries; must be a power of two.
- COLOR_W, 3, colour index width.
- clk  in  1  single pixel-domain clock.
- RESET_n  in  1  synchronous, active-low reset.
- col  in  10  current scan column.
- row  in  9  current scan row.
- video_active  in  1  high while col/row are inside the visible area.
- vblank  in  1  high while the scan is in vertical blanking.
- wr_valid  in  1  game-logic write command valid.
- wr_ready  out  1  scheduler can accept a command.
- wr_x  in  5  target cell column.
- wr_y  in  4  target cell row.
- wr_color  in  COLOR_W  colour to store.
- clear_req  in  1  one-cycle request to zero every cell.
- busy  out  1  clear pending, FIFO non-empty, or not in DISPLAY.
- frame_done  out  1  one-cycle pulse when a blanking commit finishes with the FIFO drained.
- drop_err  out  1  sticky; set when an out-of-range command is discarded.
- ram_addr  out  9  cell address = y*GRID_WIDTH + x.
- ram_we  out  1  RAM write enable.
- ram_wdata  out  COLOR_W  RAM write data.
- ram_rdata  in  COLOR_W  synchronous RAM read data, valid one cycle after ram_addr.
- cell_color  out  COLOR_W  colour of the cell under the scan, delayed by 3 cycles.

## Operation
- **FSM states:** DISPLAY, CLEAR, DRAIN.
- **Blanking edge:** vblank_q is vblank registered. rise = vblank & ~vblank_q.
- **DISPLAY:**
  - ram_we = 0.
  - ram_addr is registered from (row>>log2 BLOCK_SIZE)*GRID_WIDTH + (col>>log2 BLOCK_SIZE).
  - cell_color is registered from ram_rdata when the 2-cycle-delayed video_active is 1; otherwise it is 0.
  - On rise: go to CLEAR if clear_pending, else to DRAIN.
- **CLEAR:**
  - Writes 0 to addresses 0..GRID_WIDTH*GRID_HEIGHT-1, one per cycle (300 cycles).
  - After the last address: clear_pending <= 0, go to DRAIN.
  - If vblank falls mid-clear: abort, go to DISPLAY. clear_pending stays 1 and the clear restarts from address 0 at the next rise.
- **DRAIN:**
  - Each cycle with the FIFO non-empty: pop one entry.
  - If the entry has x < GRID_WIDTH and y < GRID_HEIGHT: ram_we = 1 at its address and colour.
  - Otherwise: no write, drop_err <= 1.
  - FIFO empty: pulse frame_done, go to DISPLAY.
  - vblank low: go to DISPLAY with no frame_done; the remaining entries wait for the next blanking.
- **FIFO:**
  - wr_ready = !full.
  - Push on wr_valid & wr_ready, in any state.
  - Push and pop in the same cycle are both honoured.
  - When full, wr_ready = 0 even if a pop occurs that cycle.
  - Commands are committed in arrival order.
- **clear_req:**
  - Sets clear_pending in any state. While already pending it has no further effect.
  - Queued FIFO commands are not flushed; they commit after the clear completes.
  - If clear_req arrives during CLEAR or DRAIN, it takes effect at the next rise.
- **Cell colour in other states:** cell_color = 0 whenever state ≠ DISPLAY.

## Timing
- **Reset** (RESET_n low at a clk edge):
  - State DISPLAY, FIFO empty, clear_pending = 1 (the board is cleared at the first blanking).
  - drop_err = 0, frame_done = 0, ram_we = 0, ram_addr = 0, ram_wdata = 0, cell_color = 0.
  - wr_ready = 1 from the first cycle after reset; busy = 1.
- **Read latency:** col/row sampled at edge N → ram_addr at N+1 → ram_rdata during N+2 → cell_color at N+3. The renderer delays its syncs by 3 cycles.
- **Entering blanking:** the first CLEAR/DRAIN write occurs 2 cycles after vblank goes high (one for edge detect, one for the state change).
- **Write throughput:** one RAM write per cycle in CLEAR and DRAIN. The empty-FIFO check uses the current count, so the last entry written and the frame_done pulse are on consecutive cycles.
- **Mid-operation reset:** an in-flight clear or drain is discarded and all reset values apply on the next edge.

## Test plan
- **Reset and first clear:** hold RESET_n low 2 cycles, release, raise vblank → wr_ready = 1, busy = 1, ram_we high for exactly 300 cycles at addresses 0..299 with data 0, then frame_done pulses once and busy = 0.
- **Buffered write:** during active video push (x=3, y=2, color=5) → no ram_we until blanking; at blanking one write at addr 43 with data 5. Preload RAM[43]=5; scan col=100, row=70 → cell_color = 5 exactly 3 cycles later.
- **FIFO full:** push 16 commands with vblank low → wr_ready = 0 after the 16th; a 17th wr_valid is not accepted. At blanking all 16 commit in order on 16 consecutive cycles.
- **Out-of-range command:** push (x=20, y=0) then (x=0, y=15) → no RAM writes, drop_err = 1 and stays set; a following valid command still commits.
- **Interrupted clear:** assert clear_req and drop vblank after 100 CLEAR cycles → state DISPLAY, busy = 1. At the next vblank the clear restarts at addr 0 and runs 300 cycles.
- **Simultaneous push/pop:** with 1 entry queued in DRAIN, push on the cycle it pops → count stays 1, the new entry commits next cycle, then frame_done pulses.
